multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the write enables for PC, IR and the register file.
- Selects the immediate generator output as ALU operand B.
- Owns the req/ack handshakes to instruction and data memory, including timeout detection and a sticky trap state.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles a memory request may wait for ack before trapping; must be >= 2.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_ack  in  1  instruction word valid on imem data this cycle
- dmem_ack  in  1  data access complete (load data valid / store committed)
- ir_opcode  in  7  bits [6:0] of the IR register output
- branch_taken  in  1  ALU compare result for the current branch
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; meaningful only while dmem_req=1
- ir_we  out  1  IR capture strobe
- pc_we  out  1  PC update strobe
- pc_sel_branch  out  1  1 = PC loads PC+imm, 0 = PC+4; meaningful only while pc_we=1
- alu_src_imm  out  1  ALU operand B = immediate generator output
- reg_we  out  1  register file write enable
- wb_sel  out  2  writeback source: 0 ALU, 1 load data, 2 immediate (LUI), 3 reserved
- trap  out  1  sticky fault flag
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timeout counter=0, instret=0, trap=0, trap_cause=0. All strobes and requests are 0, wb_sel=0.
- Outputs are Moore-decoded from state plus the opcode held in the latched class register, except where noted below.
- Opcode classes:
  - LOAD 0000011
  - OPIMM 0010011
  - STORE 0100011
  - BRANCH 1100011
  - LUI 0110111
  - OP 0110011
  - every other opcode is illegal.
- IDLE: one cycle, then FETCH.
- FETCH:
  - imem_req=1 every cycle in this state.
  - When imem_ack=1: ir_we=1 combinationally that same cycle, then DECODE next cycle. An ack in the first FETCH cycle is legal, so fetch latency is 1 cycle minimum.
- DECODE:
  - ir_opcode is sampled and the class latched.
  - Illegal opcode -> TRAP with cause 1. Otherwise -> EXEC.
- EXEC:
  - alu_src_imm=1 for LOAD, OPIMM, STORE, LUI, BRANCH.
  - BRANCH: pc_we=1, pc_sel_branch=branch_taken (combinational), then FETCH.
  - LOAD or STORE -> MEM.
  - OP, OPIMM or LUI -> WB.
- MEM:
  - dmem_req=1, dmem_we=1 for STORE, alu_src_imm=1.
  - On dmem_ack: LOAD -> WB; STORE asserts pc_we=1 (PC+4) that cycle and goes to FETCH.
- WB: reg_we=1 and pc_we=1 for one cycle, wb_sel per class (LOAD=1, LUI=2, else 0), then FETCH.
- Cycles per instruction with zero-wait memory:
  - BRANCH 3
  - STORE 4
  - OP, OPIMM, LUI 4
  - LOAD 5
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle the request is held without ack.
  - If ack is still 0 in the cycle the counter equals TIMEOUT_CYCLES-1 -> TRAP with cause 2 (FETCH) or 3 (MEM).
  - An ack arriving in that same final cycle wins; no trap.
- TRAP:
  - Terminal until reset. trap=1 and trap_cause held.
  - All strobes and requests are 0; instret frozen.
- instret increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W.
- A reset asserted mid-request drops imem_req/dmem_req asynchronously. Memory must tolerate request withdrawal.
- Never two strobes from different instructions in one cycle. reg_we and dmem_req are never both 1.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - opcode localparams (shared with the immediate generator and decoder)
  - op_class_t enum
  - wb_sel_t
  - trap_cause_t
- Sub-module mem_timeout: counter with clear/enable inputs and an expired output. Instantiated once and shared by the FETCH and MEM states.

Test Plan:
- ADDI (0x00500093), imem_ack on first FETCH cycle -> IDLE, FETCH, DECODE, EXEC, WB. reg_we=1 with wb_sel=0 in WB. instret 0->1.
- LOAD, dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 for exactly 4 cycles. WB has wb_sel=1. Total 8 cycles from FETCH entry to next FETCH.
- BRANCH with branch_taken=1, then again with branch_taken=0 -> pc_we=1 in EXEC with pc_sel_branch=1 and 0 respectively; reg_we never asserted.
- Opcode 0x7F, then imem_ack never asserted with TIMEOUT_CYCLES=16 -> first case: trap=1, cause=1, all strobes 0 thereafter. Second case: trap on the 16th FETCH cycle with cause=2.
- dmem_ack asserted in exactly the 16th MEM cycle -> no trap, instruction retires. Then assert reset low mid-MEM -> all outputs return to reset values the same cycle, and FETCH restarts after IDLE.
- LUI (0x123450B7) -> alu_src_imm=1 in EXEC, wb_sel=2 in WB; instret wraps from 2^CNT_W-1 to 0 with CNT_W=4 over 16 instructions.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle control path.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_OPIMM,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_OP,
        CLS_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_LOAD,
        WB_IMM,
        WB_RSVD
    } wb_sel_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_ILLEGAL,
        CAUSE_IMEM,
        CAUSE_DMEM
    } trap_cause_t;

    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t c;
        case (opc)
            OPC_LOAD:   c = CLS_LOAD;
            OPC_OPIMM:  c = CLS_OPIMM;
            OPC_STORE:  c = CLS_STORE;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_LUI:    c = CLS_LUI;
            OPC_OP:     c = CLS_OP;
            default:    c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_timeout.sv
// Wait-cycle counter shared by the instruction and data memory handshakes.
module mem_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    // Only meaningful while a request is still waiting for its ack.
    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory, writeback.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic [6:0]       ir_opcode,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    state_t      state;
    state_t      state_next;
    op_class_t   cls;
    trap_cause_t cause;
    trap_cause_t cause_next;
    wb_sel_t     wsel;
    logic [CNT_W-1:0] count;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cls   <= CLS_ILLEGAL;
            cause <= CAUSE_NONE;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                cls <= classify(ir_opcode);
            end
            if (state_next == TRAP && state != TRAP) begin
                cause <= cause_next;
            end
            if (pc_we) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Any state change restarts the wait count, including MEM->FETCH.
    assign tmo_clear  = (state_next != state);
    assign tmo_enable = (state == FETCH && !imem_ack)
                     || (state == MEM && !dmem_ack);

    mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next    = state;
        cause_next    = CAUSE_NONE;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        alu_src_imm   = 1'b0;
        reg_we        = 1'b0;
        wsel          = WB_ALU;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end else if (tmo_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_IMEM;
                end
            end
            DECODE: begin
                if (classify(ir_opcode) == CLS_ILLEGAL) begin
                    state_next = TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_src_imm = (cls != CLS_OP);
                if (cls == CLS_BRANCH) begin
                    pc_we         = 1'b1;
                    pc_sel_branch = branch_taken;
                    state_next    = FETCH;
                end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = (cls == CLS_STORE);
                alu_src_imm = 1'b1;
                if (dmem_ack) begin
                    if (cls == CLS_STORE) begin
                        pc_we      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (tmo_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_DMEM;
                end
            end
            WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                state_next = FETCH;
                if (cls == CLS_LOAD) begin
                    wsel = WB_LOAD;
                end else if (cls == CLS_LUI) begin
                    wsel = WB_IMM;
                end
            end
            TRAP: state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    assign wb_sel     = wsel;
    assign trap       = (state == TRAP);
    assign trap_cause = cause;
    assign instret    = count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: randomized instruction stream plus directed trap/reset cases.
module tb_multicycle_ctrl;

    localparam int TMO = 16;
    localparam int CW  = 4;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] OP     = 7'b0110011;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic [6:0]    ir_opcode = 7'h0;
    logic          branch_taken = 1'b0;
    logic          imem_req;
    logic          dmem_req;
    logic          dmem_we;
    logic          ir_we;
    logic          pc_we;
    logic          pc_sel_branch;
    logic          alu_src_imm;
    logic          reg_we;
    logic [1:0]    wb_sel;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_ack      (imem_ack),
        .dmem_ack      (dmem_ack),
        .ir_opcode     (ir_opcode),
        .branch_taken  (branch_taken),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_sel_branch (pc_sel_branch),
        .alu_src_imm   (alu_src_imm),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int exec_cyc;
        int alu;
        int pcsel;
        int regwe;
        int wbsel;
        int dcyc;
        int store;
        int ret;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   retired = 0;
    bit   mon_en = 1'b0;

    logic [9:0] strobes;
    assign strobes = {imem_req, dmem_req, dmem_we, ir_we, pc_we,
                      pc_sel_branch, alu_src_imm, reg_we, wb_sel};

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    // Monitor: tracks cycles since fetch start, compares at each retirement.
    int   cyc = 0;
    int   dcyc = 0;
    int   dwe = 0;
    logic prev_req = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_req && !prev_req) begin
                cyc  = 1;
                dcyc = 0;
                dwe  = 0;
            end else begin
                cyc++;
            end
            prev_req = imem_req;
            if (dmem_req) begin
                dcyc++;
                if (dmem_we) dwe = 1;
            end
            chk("reg_we_dmem_req_excl", int'(reg_we && dmem_req), 0);
            chk("ir_we", int'(ir_we), int'(imem_ack));
            chk("no_trap", int'(trap), 0);
            if (exp_q.size() > 0 && cyc == exp_q[0].exec_cyc) begin
                chk("alu_src_imm_exec", int'(alu_src_imm), exp_q[0].alu);
            end
            if (pc_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("cycles_to_retire", cyc, cur.lat);
                    chk("pc_sel_branch", int'(pc_sel_branch), cur.pcsel);
                    chk("reg_we", int'(reg_we), cur.regwe);
                    chk("wb_sel", int'(wb_sel), cur.wbsel);
                    chk("dmem_req_cycles", dcyc, cur.dcyc);
                    chk("dmem_we", dwe, cur.store);
                    chk("instret", int'(instret), cur.ret);
                end
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tx(input logic [6:0] op, input int ilat,
                          input int dlat, input bit taken);
        exp_t e;
        int   n;
        bit   mem;
        mem        = (op == LOAD || op == STORE);
        e.exec_cyc = ilat + 3;
        e.lat      = ilat + 3 + (mem ? dlat + 1 : 0)
                   + ((op == BRANCH || op == STORE) ? 0 : 1);
        e.alu      = (op != OP) ? 1 : 0;
        e.pcsel    = (op == BRANCH && taken) ? 1 : 0;
        e.regwe    = (op == BRANCH || op == STORE) ? 0 : 1;
        e.wbsel    = (op == LOAD) ? 1 : (op == LUI) ? 2 : 0;
        e.dcyc     = mem ? dlat + 1 : 0;
        e.store    = (op == STORE) ? 1 : 0;
        e.ret      = retired % (1 << CW);
        retired++;
        exp_q.push_back(e);

        n = 0;
        while (!imem_req && n < 64) begin
            tick();
            n++;
        end
        chk("imem_req_wait", int'(imem_req), 1);
        repeat (ilat) tick();
        imem_ack     = 1'b1;
        ir_opcode    = op;
        branch_taken = taken;
        tick();
        imem_ack = 1'b0;
        if (mem) begin
            n = 0;
            while (!dmem_req && n < 64) begin
                tick();
                n++;
            end
            chk("dmem_req_wait", int'(dmem_req), 1);
            repeat (dlat) tick();
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
        end
    endtask

    task automatic apply_reset();
        tick();
        reset    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic fetch_now(input logic [6:0] op);
        tick();
        imem_ack  = 1'b1;
        ir_opcode = op;
        tick();
        imem_ack = 1'b0;
    endtask

    function automatic int rand_lat();
        return ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
    endfunction

    logic [6:0] ops [6];
    int n;

    initial begin
        ops[0] = LOAD;  ops[1] = OPIMM; ops[2] = STORE;
        ops[3] = BRANCH; ops[4] = LUI;  ops[5] = OP;

        #1;
        chk("reset_strobes", int'(strobes), 0);
        chk("reset_trap", int'(trap), 0);
        chk("reset_cause", int'(trap_cause), 0);
        chk("reset_instret", int'(instret), 0);
        repeat (2) tick();
        reset  = 1'b1;
        mon_en = 1'b1;
        chk("idle_no_req", int'(imem_req), 0);

        run_tx(OPIMM, 0, 0, 1'b0);
        run_tx(LOAD, 0, 3, 1'b0);
        run_tx(BRANCH, 0, 0, 1'b1);
        run_tx(BRANCH, 1, 0, 1'b0);
        run_tx(LUI, 0, 0, 1'b0);
        run_tx(STORE, 2, TMO - 1, 1'b0);
        run_tx(LOAD, TMO - 1, TMO - 1, 1'b0);
        run_tx(OP, 0, 0, 1'b0);
        for (int i = 0; i < 48; i++) begin
            run_tx(ops[$urandom_range(0, 5)], rand_lat(), rand_lat(),
                   1'($urandom_range(0, 1)));
        end
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        mon_en = 1'b0;

        // Illegal opcode traps with cause 1 and stays dead.
        apply_reset();
        fetch_now(7'h7F);
        chk("illegal_decode_no_trap", int'(trap), 0);
        tick();
        chk("illegal_trap", int'(trap), 1);
        chk("illegal_cause", int'(trap_cause), 1);
        chk("illegal_strobes", int'(strobes), 0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (4) tick();
        chk("trap_sticky", int'(trap), 1);
        chk("trap_strobes_acks", int'(strobes), 0);
        chk("trap_instret", int'(instret), 0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // Instruction fetch never acked.
        apply_reset();
        tick();
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            tick();
        end
        chk("imem_tmo_cycles", n, TMO);
        chk("imem_tmo_trap", int'(trap), 1);
        chk("imem_tmo_cause", int'(trap_cause), 2);

        // Load whose data access is never acked.
        apply_reset();
        fetch_now(LOAD);
        repeat (2) tick();
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            chk("dmem_tmo_we", int'(dmem_we), 0);
            tick();
        end
        chk("dmem_tmo_cycles", n, TMO);
        chk("dmem_tmo_trap", int'(trap), 1);
        chk("dmem_tmo_cause", int'(trap_cause), 3);

        // Asynchronous reset in the middle of a data request.
        apply_reset();
        fetch_now(STORE);
        repeat (2) tick();
        chk("mem_req_before_rst", int'(dmem_req), 1);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("async_rst_strobes", int'(strobes), 0);
        chk("async_rst_trap", int'(trap), 0);
        chk("async_rst_instret", int'(instret), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_release_idle", int'(imem_req), 0);
        tick();
        chk("rst_release_fetch", int'(imem_req), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
